prio_q_nway: RTL and testbench
==============================

PRIO_Q_NWAY -- requirements
Module: prio_q_nway

Interface
REQ-001 Parameter WIDTH, default 32: data port width.
REQ-002 Parameter CMP_WID, default 32: only CMP_WID LSBs of an entry are compared; smaller is higher priority.
REQ-003 Parameter DEPTH, default 5: depth of each heap lane; lane capacity is 2^DEPTH-1.
REQ-004 Parameter NUM_HEAP, default 4: lane count, a power of two from 2 to 8; LOG_HEAP = log2(NUM_HEAP).
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 enq  input  1  enqueue request.
REQ-008 inp_data  input  WIDTH  enqueue data.
REQ-009 deq  input  1  dequeue request; honoured only while out_vld=1.
REQ-010 out_data  output  WIDTH  registered minimum entry.
REQ-011 out_vld  output  1  out_data is the current global minimum and may be dequeued.
REQ-012 elem_cnt  output  DEPTH+LOG_HEAP+1  total entries stored.
REQ-013 full / empty  output  1 each  all lanes full / all lanes empty.
REQ-014 ovf / udf  output  1 each  sticky flags for a dropped enqueue / a dequeue attempted while empty.
REQ-015 hwm  output  DEPTH+LOG_HEAP+1  high-water mark of elem_cnt.
REQ-016 clr_flags  input  1  synchronous clear of ovf, udf and hwm.

Function
REQ-017 The block instantiates NUM_HEAP copies of the team heap prio_q; each copy updates at the edge after its enq or deq is asserted.
REQ-018 The block keeps one DEPTH-bit occupancy counter per lane, updated in the same cycle as the lane enq/deq.
REQ-019 Enqueue steering selects the non-full lane with the lowest occupancy, ties to the lowest index, excluding any lane dequeued in the same cycle.
REQ-020 enq with full=1, or with no eligible lane, drops the data, sets ovf and leaves all state unchanged.
REQ-021 The minimum search is a log2 comparator tree over non-empty lane heads; on equal keys the lower index wins.
REQ-022 FSM states: EMPTY, REFRESH, VALID.
REQ-023 EMPTY to REFRESH on an accepted enq.
REQ-024 VALID to REFRESH on an accepted enq or deq.
REQ-025 REFRESH captures the tree result (data and lane id) into the out_data / sel_id registers.
REQ-026 REFRESH goes to VALID if elem_cnt is nonzero and no enq or deq is accepted that cycle, to EMPTY if elem_cnt=0, and stays in REFRESH otherwise.
REQ-027 out_vld = (state == VALID).
REQ-028 An accepted deq asserts deq only on lane sel_id; out_data is not updated until the next REFRESH.
REQ-029 deq with out_vld=0 has no effect; if empty=1 it also sets udf.
REQ-030 Simultaneous enq and deq in VALID are both accepted; the enq lane is never sel_id.
REQ-031 elem_cnt is the sum of the lane counters; it never wraps, because ovf/udf suppress the update.
REQ-032 hwm = max(hwm, elem_cnt), registered.
REQ-033 clr_flags takes priority over a same-cycle set of ovf, udf or hwm.
REQ-034 Latency: enq into an empty block gives out_vld=1 two cycles later; a deq in VALID gives the next minimum two cycles later.

Reset
REQ-035 rst_n low asynchronously forces state EMPTY and clears all lane counters.
REQ-036 Reset values: out_data=0, out_vld=0, elem_cnt=0, empty=1, full=0, ovf=0, udf=0, hwm=0, sel_id=0.
REQ-037 Reset mid-operation discards all entries; the lanes share rst_n.

Verification (NUM_HEAP=4, DEPTH=3, capacity 28)
REQ-038 Enq 9,3,7,5 on consecutive cycles -> lanes 0,1,2,3 each hold 1 entry; out_vld rises 2 cycles after the last enq; out_data=3.
REQ-039 Continuing REQ-038, deq whenever out_vld=1 -> outputs 3,5,7,9 in order, each 2 cycles apart; then empty=1, out_vld=0.
REQ-040 28 enqueues then 1 more -> full=1, ovf=1, elem_cnt=28, hwm=28; assert clr_flags -> ovf=0, hwm=28 (current count).
REQ-041 deq while empty -> udf=1, elem_cnt stays 0; deq during REFRESH with entries present -> ignored, udf stays 0.
REQ-042 In VALID with head 4 in lane 2, enq 1 and deq in the same cycle -> 4 removed, 1 steered to a lane other than 2, out_data=1 two cycles later.
REQ-043 rst_n low for 1 cycle mid-stream with 10 entries -> all outputs take their reset values immediately, and a subsequent enq 6 gives out_data=6.

Source files
------------

// File: rtl/prio_q_nway.sv
// prio_q_nway: multi-lane priority queue built from NUM_HEAP prio_q lanes.
// Enqueues are balanced across lanes, and a comparator tree selects the global minimum.
// The minimum is registered into out_data by a small EMPTY/REFRESH/VALID FSM.

// prio_q: one lane holding up to 2^DEPTH-1 entries, kept sorted ascending so
// that the head (slot 0) is always the lane minimum. Updates on the edge after
// i_enq/i_deq. The caller never asserts both in the same cycle and never
// enqueues into a full lane or dequeues from an empty lane.
module prio_q #(
   parameter int WIDTH   = 32,
   parameter int CMP_WID = 32,
   parameter int DEPTH   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_enq,
   input  logic             i_deq,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_head
);
   localparam int CAP = (1 << DEPTH) - 1;

   logic [WIDTH-1:0] r_data [CAP];
   logic [CAP-1:0]   r_vld;
   logic [WIDTH-1:0] w_nextData [CAP];
   logic [CAP-1:0]   w_nextVld;
   logic [CAP-1:0]   w_le;

   // Marks stored entries whose key is <= the incoming key (a prefix, since the lane is sorted)
   always_comb begin
      w_le = '0;
      for (int i = 0; i < CAP; i++)
         w_le[i] = r_vld[i] && (r_data[i][CMP_WID-1:0] <= i_data[CMP_WID-1:0]);
   end

   // Next lane contents: shift toward the head on dequeue, insert in order on enqueue
   always_comb begin
      w_nextData = r_data;
      w_nextVld  = r_vld;
      if (i_deq) begin
         for (int i = 0; i < CAP - 1; i++) begin
            w_nextData[i] = r_data[i+1];
            w_nextVld[i]  = r_vld[i+1];
         end
         w_nextData[CAP-1] = '0;
         w_nextVld[CAP-1]  = 1'b0;
      end else if (i_enq) begin
         if (!w_le[0])
            w_nextData[0] = i_data;
         w_nextVld[0] = 1'b1;
         for (int i = 1; i < CAP; i++) begin
            if (!w_le[i])
               w_nextData[i] = w_le[i-1] ? i_data : r_data[i-1];
            w_nextVld[i] = r_vld[i] | r_vld[i-1];
         end
      end
   end

   // Lane storage registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CAP; i++)
            r_data[i] <= '0;
         r_vld <= '0;
      end else begin
         r_data <= w_nextData;
         r_vld  <= w_nextVld;
      end
   end

   assign o_head = r_data[0];
endmodule

module prio_q_nway #(
   parameter int WIDTH    = 32,
   parameter int CMP_WID  = 32,
   parameter int DEPTH    = 5,
   parameter int NUM_HEAP = 4
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  enq,
   input  logic [WIDTH-1:0]                      inp_data,
   input  logic                                  deq,
   input  logic                                  clr_flags,
   output logic [WIDTH-1:0]                      out_data,
   output logic                                  out_vld,
   output logic [DEPTH+$clog2(NUM_HEAP):0]       elem_cnt,
   output logic                                  full,
   output logic                                  empty,
   output logic                                  ovf,
   output logic                                  udf,
   output logic [DEPTH+$clog2(NUM_HEAP):0]       hwm
);
   localparam int LOG_HEAP = $clog2(NUM_HEAP);
   localparam int CW       = DEPTH + LOG_HEAP + 1;
   localparam logic [DEPTH-1:0] LANE_CAP = '1;

   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_REFRESH = 2'd1;
   localparam logic [1:0] ST_VALID   = 2'd2;

   logic [1:0]          r_state;
   logic [DEPTH-1:0]    r_cnt [NUM_HEAP];
   logic [WIDTH-1:0]    r_outData;
   logic [LOG_HEAP-1:0] r_selId;
   logic                r_ovf;
   logic                r_udf;
   logic [CW-1:0]       r_hwm;

   logic [WIDTH-1:0]    w_head [NUM_HEAP];
   logic [NUM_HEAP-1:0] w_laneEnq;
   logic [NUM_HEAP-1:0] w_laneDeq;
   logic [CW-1:0]       w_elemCnt;
   logic                w_full;
   logic                w_empty;
   logic                w_deqAcc;
   logic                w_enqAcc;
   logic                w_enqOk;
   logic [LOG_HEAP-1:0] w_enqLane;
   logic [DEPTH-1:0]    w_bestCnt;

   // Comparator tree is always built 8 leaves wide; unused leaves are invalid
   logic             w_leafVld  [8];
   logic [WIDTH-1:0] w_leafData [8];
   logic             w_l1Vld  [4];
   logic [WIDTH-1:0] w_l1Data [4];
   logic [2:0]       w_l1Id   [4];
   logic             w_l2Vld  [2];
   logic [WIDTH-1:0] w_l2Data [2];
   logic [2:0]       w_l2Id   [2];
   logic             w_l3Vld;
   logic [WIDTH-1:0] w_l3Data;
   logic [2:0]       w_l3Id;
   logic [WIDTH-1:0]    w_minData;
   logic [LOG_HEAP-1:0] w_minId;

   function automatic logic takeLeft(input logic vL, input logic [WIDTH-1:0] dL,
                                     input logic vR, input logic [WIDTH-1:0] dR);
      return vL && (!vR || (dL[CMP_WID-1:0] <= dR[CMP_WID-1:0]));
   endfunction

   genvar g;
   generate
      for (g = 0; g < NUM_HEAP; g++) begin : g_lane
         prio_q #(.WIDTH(WIDTH), .CMP_WID(CMP_WID), .DEPTH(DEPTH)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_enq  (w_laneEnq[g]),
            .i_deq  (w_laneDeq[g]),
            .i_data (inp_data),
            .o_head (w_head[g])
         );
      end
      for (g = 0; g < 8; g++) begin : g_leaf
         if (g < NUM_HEAP) begin : g_used
            assign w_leafVld[g]  = (r_cnt[g] != '0);
            assign w_leafData[g] = w_head[g];
         end else begin : g_pad
            assign w_leafVld[g]  = 1'b0;
            assign w_leafData[g] = '0;
         end
      end
   endgenerate

   // Tree level 1: pairs of lane heads, lower index wins on equal keys
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_l1Vld[i]  = 1'b0;
         w_l1Data[i] = '0;
         w_l1Id[i]   = '0;
         if (takeLeft(w_leafVld[2*i], w_leafData[2*i], w_leafVld[2*i+1], w_leafData[2*i+1])) begin
            w_l1Vld[i]  = w_leafVld[2*i];
            w_l1Data[i] = w_leafData[2*i];
            w_l1Id[i]   = 3'(2*i);
         end else begin
            w_l1Vld[i]  = w_leafVld[2*i+1];
            w_l1Data[i] = w_leafData[2*i+1];
            w_l1Id[i]   = 3'(2*i+1);
         end
      end
   end

   // Tree level 2
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         w_l2Vld[i]  = 1'b0;
         w_l2Data[i] = '0;
         w_l2Id[i]   = '0;
         if (takeLeft(w_l1Vld[2*i], w_l1Data[2*i], w_l1Vld[2*i+1], w_l1Data[2*i+1])) begin
            w_l2Vld[i]  = w_l1Vld[2*i];
            w_l2Data[i] = w_l1Data[2*i];
            w_l2Id[i]   = w_l1Id[2*i];
         end else begin
            w_l2Vld[i]  = w_l1Vld[2*i+1];
            w_l2Data[i] = w_l1Data[2*i+1];
            w_l2Id[i]   = w_l1Id[2*i+1];
         end
      end
   end

   // Tree root; an all-empty tree reports zero data
   always_comb begin
      if (takeLeft(w_l2Vld[0], w_l2Data[0], w_l2Vld[1], w_l2Data[1])) begin
         w_l3Vld  = w_l2Vld[0];
         w_l3Data = w_l2Data[0];
         w_l3Id   = w_l2Id[0];
      end else begin
         w_l3Vld  = w_l2Vld[1];
         w_l3Data = w_l2Data[1];
         w_l3Id   = w_l2Id[1];
      end
   end

   assign w_minData = w_l3Vld ? w_l3Data : '0;
   assign w_minId   = w_l3Id[LOG_HEAP-1:0];

   // Total occupancy and the all-lanes-full condition
   always_comb begin
      w_elemCnt = '0;
      w_full    = 1'b1;
      for (int i = 0; i < NUM_HEAP; i++) begin
         w_elemCnt = w_elemCnt + CW'(r_cnt[i]);
         if (r_cnt[i] != LANE_CAP)
            w_full = 1'b0;
      end
   end

   assign w_empty  = (w_elemCnt == '0);
   assign w_deqAcc = deq && (r_state == ST_VALID);

   // Enqueue steering: least-occupied non-full lane, lowest index on ties, never the lane being dequeued
   always_comb begin
      w_enqOk   = 1'b0;
      w_enqLane = '0;
      w_bestCnt = '1;
      for (int i = 0; i < NUM_HEAP; i++) begin
         if ((r_cnt[i] != LANE_CAP) && !(w_deqAcc && (r_selId == LOG_HEAP'(i))) &&
             (!w_enqOk || (r_cnt[i] < w_bestCnt))) begin
            w_enqOk   = 1'b1;
            w_enqLane = LOG_HEAP'(i);
            w_bestCnt = r_cnt[i];
         end
      end
   end

   assign w_enqAcc = enq && !w_full && w_enqOk;

   // Per-lane enqueue/dequeue strobes
   always_comb begin
      w_laneEnq = '0;
      w_laneDeq = '0;
      if (w_enqAcc)
         w_laneEnq[w_enqLane] = 1'b1;
      if (w_deqAcc)
         w_laneDeq[r_selId] = 1'b1;
   end

   // Lane occupancy counters track the lanes edge for edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_HEAP; i++)
            r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_HEAP; i++) begin
            if (w_laneEnq[i])
               r_cnt[i] <= r_cnt[i] + 1'b1;
            else if (w_laneDeq[i])
               r_cnt[i] <= r_cnt[i] - 1'b1;
         end
      end
   end

   // Output FSM: any accepted operation forces a REFRESH of the registered minimum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY:   if (w_enqAcc) r_state <= ST_REFRESH;
            ST_REFRESH: begin
               if (w_enqAcc || w_deqAcc)
                  r_state <= ST_REFRESH;
               else if (w_elemCnt != '0)
                  r_state <= ST_VALID;
               else
                  r_state <= ST_EMPTY;
            end
            ST_VALID:   if (w_enqAcc || w_deqAcc) r_state <= ST_REFRESH;
            default:    r_state <= ST_EMPTY;
         endcase
      end
   end

   // Capture the tree result while refreshing; held stable in VALID
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outData <= '0;
         r_selId   <= '0;
      end else if (r_state == ST_REFRESH) begin
         r_outData <= w_minData;
         r_selId   <= w_minId;
      end
   end

   // Sticky status: clearing wins, and the high-water mark restarts from the current count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
         r_hwm <= '0;
      end else if (clr_flags) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
         r_hwm <= w_elemCnt;
      end else begin
         if (enq && !w_enqAcc)
            r_ovf <= 1'b1;
         if (deq && !w_deqAcc && w_empty)
            r_udf <= 1'b1;
         if (w_elemCnt > r_hwm)
            r_hwm <= w_elemCnt;
      end
   end

   assign out_data = r_outData;
   assign out_vld  = (r_state == ST_VALID);
   assign elem_cnt = w_elemCnt;
   assign full     = w_full;
   assign empty    = w_empty;
   assign ovf      = r_ovf;
   assign udf      = r_udf;
   assign hwm      = r_hwm;
endmodule

// File: tb/tb_prio_q_nway.sv
// tb_prio_q_nway: directed scoreboard bench for prio_q_nway (4 lanes, depth 3, 28 entries).
// Stimulus pushes each expected minimum into a queue; a monitor pops and compares
// every time out_vld rises. Status outputs are compared directly after each step.
module tb_prio_q_nway;
   localparam int WIDTH    = 32;
   localparam int CMP_WID  = 32;
   localparam int DEPTH    = 3;
   localparam int NUM_HEAP = 4;
   localparam int CW       = DEPTH + 2 + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             enq;
   logic [WIDTH-1:0] inp_data;
   logic             deq;
   logic             clr_flags;
   logic [WIDTH-1:0] out_data;
   logic             out_vld;
   logic [CW-1:0]    elem_cnt;
   logic             full;
   logic             empty;
   logic             ovf;
   logic             udf;
   logic [CW-1:0]    hwm;

   int               errors = 0;
   int               checks = 0;
   logic [WIDTH-1:0] expQ [$];
   logic             prevVld = 1'b0;

   prio_q_nway #(.WIDTH(WIDTH), .CMP_WID(CMP_WID), .DEPTH(DEPTH), .NUM_HEAP(NUM_HEAP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enq       (enq),
      .inp_data  (inp_data),
      .deq       (deq),
      .clr_flags (clr_flags),
      .out_data  (out_data),
      .out_vld   (out_vld),
      .elem_cnt  (elem_cnt),
      .full      (full),
      .empty     (empty),
      .ovf       (ovf),
      .udf       (udf),
      .hwm       (hwm)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, then return 1 time unit after the capturing edge
   task automatic applyStimulus(input logic e, input logic [WIDTH-1:0] d,
                                input logic q, input logic c);
      enq = e; inp_data = d; deq = q; clr_flags = c;
      @(posedge clk); #1;
      enq = 1'b0; deq = 1'b0; clr_flags = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic waitValid(input int bound);
      int n = 0;
      while (!out_vld && n < bound) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!out_vld) begin
         errors++;
         $display("[TB] FAIL waitValid: out_vld=%0b after %0d cycles, expected 1", out_vld, n);
      end
   endtask

   task automatic drainOne();
      waitValid(20);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
   endtask

   // Scoreboard monitor: every new presentation of out_vld must match the next expected minimum
   always @(negedge clk) begin
      if (out_vld && !prevVld) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedOutput: got %0d, expected no output", out_data);
         end else begin
            checkOutput("scoreboard", out_data, expQ.pop_front());
         end
      end
      prevVld = out_vld;
   end

   initial begin
      rst_n = 1'b0; enq = 1'b0; deq = 1'b0; clr_flags = 1'b0; inp_data = '0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      $display("[TB] reset values");
      checkOutput("rstOutData", out_data, 0);
      checkOutput("rstOutVld", 32'(out_vld), 0);
      checkOutput("rstElemCnt", 32'(elem_cnt), 0);
      checkOutput("rstEmpty", 32'(empty), 1);
      checkOutput("rstFull", 32'(full), 0);
      checkOutput("rstOvf", 32'(ovf), 0);
      checkOutput("rstUdf", 32'(udf), 0);
      checkOutput("rstHwm", 32'(hwm), 0);

      $display("[TB] enqueue 9,3,7,5 then drain");
      expQ.push_back(3);
      applyStimulus(1'b1, 9, 1'b0, 1'b0);
      applyStimulus(1'b1, 3, 1'b0, 1'b0);
      applyStimulus(1'b1, 7, 1'b0, 1'b0);
      applyStimulus(1'b1, 5, 1'b0, 1'b0);
      checkOutput("enqCnt4", 32'(elem_cnt), 4);
      checkOutput("enqVldLate", 32'(out_vld), 0);
      idle(1);
      checkOutput("enqVldRise", 32'(out_vld), 1);
      checkOutput("enqMin3", out_data, 3);
      expQ.push_back(5); expQ.push_back(7); expQ.push_back(9);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, '0, 1'b1, 1'b0);
         checkOutput("deqRefresh", 32'(out_vld), 0);
         idle(1);
         if (k < 3) begin
            checkOutput("deqVld", 32'(out_vld), 1);
         end else begin
            checkOutput("drainVld", 32'(out_vld), 0);
            checkOutput("drainEmpty", 32'(empty), 1);
         end
      end

      $display("[TB] dequeue while empty, then clear");
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("udfSet", 32'(udf), 1);
      checkOutput("udfCnt", 32'(elem_cnt), 0);
      checkOutput("hwmAfter4", 32'(hwm), 4);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("udfClr", 32'(udf), 0);
      checkOutput("hwmClr", 32'(hwm), 0);

      $display("[TB] dequeue during refresh is ignored");
      expQ.push_back(20);
      applyStimulus(1'b1, 20, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("refDeqUdf", 32'(udf), 0);
      checkOutput("refDeqCnt", 32'(elem_cnt), 1);
      drainOne();
      idle(1);
      checkOutput("refDrainEmpty", 32'(empty), 1);

      $display("[TB] fill to capacity and overflow");
      expQ.push_back(50);
      for (int k = 0; k < 28; k++)
         applyStimulus(1'b1, 32'(50 + k), 1'b0, 1'b0);
      checkOutput("fillFull", 32'(full), 1);
      applyStimulus(1'b1, 1, 1'b0, 1'b0);
      checkOutput("ovfSet", 32'(ovf), 1);
      checkOutput("ovfCnt", 32'(elem_cnt), 28);
      checkOutput("ovfHwm", 32'(hwm), 28);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("ovfClr", 32'(ovf), 0);
      checkOutput("hwmKeep", 32'(hwm), 28);
      checkOutput("fullKeep", 32'(full), 1);
      for (int k = 1; k < 28; k++)
         expQ.push_back(32'(50 + k));
      for (int k = 0; k < 28; k++)
         drainOne();
      idle(2);
      checkOutput("bigDrainEmpty", 32'(empty), 1);
      checkOutput("bigDrainCnt", 32'(elem_cnt), 0);

      $display("[TB] simultaneous enqueue and dequeue");
      expQ.push_back(4);
      applyStimulus(1'b1, 9, 1'b0, 1'b0);
      applyStimulus(1'b1, 8, 1'b0, 1'b0);
      applyStimulus(1'b1, 4, 1'b0, 1'b0);
      applyStimulus(1'b1, 7, 1'b0, 1'b0);
      waitValid(10);
      checkOutput("simHead4", out_data, 4);
      expQ.push_back(1);
      applyStimulus(1'b1, 1, 1'b1, 1'b0);
      checkOutput("simCnt", 32'(elem_cnt), 4);
      checkOutput("simRefresh", 32'(out_vld), 0);
      idle(1);
      checkOutput("simVld", 32'(out_vld), 1);
      checkOutput("simMin1", out_data, 1);
      expQ.push_back(7); expQ.push_back(8); expQ.push_back(9);
      for (int k = 0; k < 4; k++)
         drainOne();
      idle(2);
      checkOutput("simDrainEmpty", 32'(empty), 1);

      $display("[TB] asynchronous reset mid-stream");
      expQ.push_back(30);
      for (int k = 0; k < 10; k++)
         applyStimulus(1'b1, 32'(30 + k), 1'b0, 1'b0);
      waitValid(10);
      idle(1);
      rst_n = 1'b0;
      #2;
      checkOutput("arstVld", 32'(out_vld), 0);
      checkOutput("arstData", out_data, 0);
      checkOutput("arstCnt", 32'(elem_cnt), 0);
      checkOutput("arstEmpty", 32'(empty), 1);
      checkOutput("arstHwm", 32'(hwm), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(1);
      expQ.push_back(6);
      applyStimulus(1'b1, 6, 1'b0, 1'b0);
      idle(1);
      checkOutput("postRstVld", 32'(out_vld), 1);
      checkOutput("postRstData", out_data, 6);
      drainOne();
      idle(2);

      checkOutput("sbDrained", 32'(expQ.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
